// File: rtl/noc_router_slot_table_pkg.sv
// Shared NoC definitions for the TDM slot table: select/slot width helpers,
// the idle-select encoding and the per-port select type.
package noc_router_slot_table_pkg;

    localparam int unsigned DEF_MAX_PORTS = 6;
    localparam int unsigned DEF_LUT_SIZE  = 8;

    // Never returns zero so single-entry configurations still get a real bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Selects carry one extra code point for "idle".
    function automatic int unsigned sel_width(input int unsigned max_ports);
        return clog2_min1(max_ports + 1);
    endfunction

    function automatic int unsigned slot_width(input int unsigned lut_size);
        return clog2_min1(lut_size);
    endfunction

    function automatic int unsigned idle_code(input int unsigned max_ports);
        return max_ports;
    endfunction

    function automatic logic below(input int unsigned value, input int unsigned limit);
        return value < limit;
    endfunction

    localparam int unsigned DEF_SEL_W  = sel_width(DEF_MAX_PORTS);
    localparam int unsigned DEF_SLOT_W = slot_width(DEF_LUT_SIZE);

    typedef logic [DEF_SEL_W-1:0] port_sel_t;

endpackage

// File: rtl/noc_router_slot_table_counter.sv
// TDM slot counter: increments every cycle, wraps at LUT_SIZE-1 and
// restarts at slot 0 the cycle after a sync pulse.
module noc_slot_counter #(
    parameter int unsigned LUT_SIZE = 8,
    parameter int unsigned SLOT_W   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sync,
    output logic [SLOT_W-1:0] o_slot,
    output logic [SLOT_W-1:0] o_slot_next
);

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(LUT_SIZE - 1);

    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_next;

    always_comb begin
        w_slot_next = r_slot + SLOT_W'(1);
        if (i_sync || (r_slot == LAST)) begin
            w_slot_next = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    assign o_slot      = r_slot;
    assign o_slot_next = w_slot_next;

endmodule

// File: rtl/noc_router_slot_table.sv
// Per-router TDM slot table: validated configuration writes into a
// port x slot table, read out each cycle for the slot being executed.
module noc_router_slot_table
    import noc_router_slot_table_pkg::*;
#(
    parameter int unsigned X         = 3,
    parameter int unsigned Y         = 3,
    parameter int unsigned NODE_ID   = 0,
    parameter int unsigned LUT_SIZE  = 8,
    parameter int unsigned MAX_PORTS = 6,
    localparam int unsigned NODES    = X * Y,
    localparam int unsigned SEL_W    = sel_width(MAX_PORTS),
    localparam int unsigned PORT_W   = clog2_min1(MAX_PORTS),
    localparam int unsigned SLOT_W   = slot_width(LUT_SIZE),
    localparam int unsigned NODE_W   = clog2_min1(NODES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [SEL_W-1:0]                  lut_conf_data,
    input  logic [PORT_W-1:0]                 lut_conf_sel,
    input  logic [SLOT_W-1:0]                 lut_conf_slot,
    input  logic [NODE_W-1:0]                 config_node,
    input  logic                              lut_conf_valid,
    input  logic                              tdm_sync,
    output logic [SLOT_W-1:0]                 cur_slot,
    output logic [MAX_PORTS-1:0][SEL_W-1:0]   out_sel,
    output logic                              conf_error
);

    localparam logic [SEL_W-1:0]  IDLE     = SEL_W'(idle_code(MAX_PORTS));
    localparam logic [NODE_W-1:0] NODE_SEL = NODE_W'(NODE_ID);

    logic [MAX_PORTS-1:0][LUT_SIZE-1:0][SEL_W-1:0] r_table;
    logic [MAX_PORTS-1:0][SEL_W-1:0]               r_out_sel;
    logic                                          r_conf_error;

    logic [SLOT_W-1:0]               w_slot;
    logic [SLOT_W-1:0]               w_slot_next;
    logic [MAX_PORTS-1:0][SEL_W-1:0] w_row_next;
    logic                            w_hit;
    logic                            w_sel_ok;
    logic                            w_slot_ok;
    logic                            w_data_ok;
    logic                            w_conflict;
    logic                            w_do_write;
    logic                            w_reject;

    noc_slot_counter #(
        .LUT_SIZE (LUT_SIZE),
        .SLOT_W   (SLOT_W)
    ) u_slot_counter (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_sync      (tdm_sync),
        .o_slot      (w_slot),
        .o_slot_next (w_slot_next)
    );

    assign w_hit     = lut_conf_valid && (config_node == NODE_SEL);
    assign w_sel_ok  = below(32'(lut_conf_sel), MAX_PORTS);
    assign w_slot_ok = below(32'(lut_conf_slot), LUT_SIZE);
    assign w_data_ok = below(32'(lut_conf_data), MAX_PORTS + 1);

    // An input port may feed at most one output port within a slot; idle never conflicts.
    always_comb begin
        w_conflict = 1'b0;
        if (w_slot_ok && w_data_ok && (lut_conf_data != IDLE)) begin
            for (int unsigned p = 0; p < MAX_PORTS; p++) begin
                if ((PORT_W'(p) != lut_conf_sel) &&
                    (r_table[PORT_W'(p)][lut_conf_slot] == lut_conf_data)) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    assign w_reject   = w_hit && (!w_sel_ok || !w_slot_ok || !w_data_ok || w_conflict);
    assign w_do_write = w_hit && !w_reject;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_table <= {(MAX_PORTS * LUT_SIZE){IDLE}};
        end else if (w_do_write) begin
            r_table[lut_conf_sel][lut_conf_slot] <= lut_conf_data;
        end
    end

    always_comb begin
        w_row_next = '0;
        for (int unsigned p = 0; p < MAX_PORTS; p++) begin
            w_row_next[PORT_W'(p)] = r_table[PORT_W'(p)][w_slot_next];
        end
    end

    // Row is loaded alongside the counter from the pre-edge table, so a write
    // landing on the slot being loaded shows up on that slot's next pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_sel    <= {MAX_PORTS{IDLE}};
            r_conf_error <= 1'b0;
        end else begin
            r_out_sel <= w_row_next;
            if (w_reject) begin
                r_conf_error <= 1'b1;
            end
        end
    end

    assign cur_slot   = w_slot;
    assign out_sel    = r_out_sel;
    assign conf_error = r_conf_error;

endmodule

// File: tb/tb_noc_router_slot_table.sv
// Directed bench for noc_router_slot_table with NODE_ID=4 on a 3x3 mesh,
// 8 slots and 6 ports (idle select = 6).
module tb_noc_router_slot_table;
    import noc_router_slot_table_pkg::*;

    logic            clk;
    logic            rst;
    logic [2:0]      lut_conf_data;
    logic [2:0]      lut_conf_sel;
    logic [2:0]      lut_conf_slot;
    logic [3:0]      config_node;
    logic            lut_conf_valid;
    logic            tdm_sync;
    logic [2:0]      cur_slot;
    logic [5:0][2:0] out_sel;
    logic            conf_error;

    int checks;
    int passes;

    // Hand-maintained expected table contents (port x slot).
    port_sel_t m_tab [6][8];

    noc_router_slot_table #(
        .X         (3),
        .Y         (3),
        .NODE_ID   (4),
        .LUT_SIZE  (8),
        .MAX_PORTS (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lut_conf_data  (lut_conf_data),
        .lut_conf_sel   (lut_conf_sel),
        .lut_conf_slot  (lut_conf_slot),
        .config_node    (config_node),
        .lut_conf_valid (lut_conf_valid),
        .tdm_sync       (tdm_sync),
        .cur_slot       (cur_slot),
        .out_sel        (out_sel),
        .conf_error     (conf_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0][2:0] exp_vec(input int s);
        logic [5:0][2:0] v;
        for (int p = 0; p < 6; p++) v[p] = m_tab[p][s];
        return v;
    endfunction

    task automatic clear_model();
        for (int p = 0; p < 6; p++)
            for (int s = 0; s < 8; s++) m_tab[p][s] = 3'd6;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        lut_conf_valid = 1'b0;
        tdm_sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    task automatic wait_slot(input int k, output bit ok);
        int n;
        n = 0;
        while (cur_slot !== 3'(k) && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (cur_slot === 3'(k));
    endtask

    // Called at a negedge: strobe is live for exactly one rising edge.
    task automatic do_write(input int sel, input int slot, input int data, input int node);
        lut_conf_sel   = 3'(sel);
        lut_conf_slot  = 3'(slot);
        lut_conf_data  = 3'(data);
        config_node    = 4'(node);
        lut_conf_valid = 1'b1;
        @(negedge clk);
        lut_conf_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lut_conf_valid = 1'b0;
        tdm_sync = 1'b0;
        lut_conf_sel = '0;
        lut_conf_slot = '0;
        lut_conf_data = '0;
        config_node = '0;
        clear_model();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (cur_slot !== 3'd0) $display("FAIL reset_cur_slot: got %0d expected 0", cur_slot);
        else passes++;
        checks++;
        if (conf_error !== 1'b0) $display("FAIL reset_conf_error: got %0b expected 0", conf_error);
        else passes++;
        checks++;
        if (out_sel !== exp_vec(0)) $display("FAIL reset_out_sel: got %h expected %h", out_sel, exp_vec(0));
        else passes++;
        // Strobe during reset must be ignored.
        lut_conf_sel = 3'd0; lut_conf_slot = 3'd1; lut_conf_data = 3'd3; config_node = 4'd4;
        lut_conf_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lut_conf_valid = 1'b0;
        rst = 1'b1;
        checks++;
        if (conf_error !== 1'b0) $display("FAIL reset_strobe_err: got %0b expected 0", conf_error);
        else passes++;
    endtask

    task automatic test_wrap();
        checks++;
        if (cur_slot !== 3'd0) $display("FAIL wrap_start: got %0d expected 0", cur_slot);
        else passes++;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (cur_slot !== 3'(i % 8)) $display("FAIL wrap_slot_%0d: got %0d expected %0d", i, cur_slot, i % 8);
            else passes++;
            checks++;
            if (out_sel !== exp_vec(i % 8)) $display("FAIL wrap_out_%0d: got %h expected %h", i, out_sel, exp_vec(i % 8));
            else passes++;
        end
    endtask

    task automatic test_foreign();
        bit ok;
        do_write(2, 3, 1, 5);
        do_write(7, 3, 1, 5);
        checks++;
        if (conf_error !== 1'b0) $display("FAIL foreign_err: got %0b expected 0", conf_error);
        else passes++;
        wait_slot(0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL foreign_wait: got slot %0d expected 0", cur_slot);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_sel !== exp_vec(i)) $display("FAIL foreign_out_%0d: got %h expected %h", i, out_sel, exp_vec(i));
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_basic_write();
        bit ok;
        wait_slot(5, ok);
        do_write(2, 3, 1, 4);
        m_tab[2][3] = 3'd1;
        checks++;
        if (conf_error !== 1'b0) $display("FAIL basic_err: got %0b expected 0", conf_error);
        else passes++;
        do_write(2, 3, 1, 4);
        do_write(4, 6, 6, 4);
        checks++;
        if (conf_error !== 1'b0) $display("FAIL rewrite_idle_err: got %0b expected 0", conf_error);
        else passes++;
        wait_slot(0, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL basic_wait: got slot %0d expected 0", cur_slot);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_sel[2] !== ((i == 3) ? 3'd1 : 3'd6))
                $display("FAIL basic_port2_%0d: got %0d expected %0d", i, out_sel[2], (i == 3) ? 1 : 6);
            else passes++;
            checks++;
            if (out_sel !== exp_vec(i)) $display("FAIL basic_out_%0d: got %h expected %h", i, out_sel, exp_vec(i));
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_conflict();
        bit ok;
        do_write(0, 1, 2, 4);
        m_tab[0][1] = 3'd2;
        checks++;
        if (conf_error !== 1'b0) $display("FAIL conflict_first_err: got %0b expected 0", conf_error);
        else passes++;
        do_write(3, 1, 2, 4);
        checks++;
        if (conf_error !== 1'b1) $display("FAIL conflict_err: got %0b expected 1", conf_error);
        else passes++;
        wait_slot(1, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL conflict_wait: got slot %0d expected 1", cur_slot);
        else passes++;
        checks++;
        if (out_sel[3] !== 3'd6) $display("FAIL conflict_port3: got %0d expected 6", out_sel[3]);
        else passes++;
        checks++;
        if (out_sel[0] !== 3'd2) $display("FAIL conflict_port0: got %0d expected 2", out_sel[0]);
        else passes++;
    endtask

    task automatic test_live_slot();
        bit ok;
        wait_slot(4, ok);
        checks++;
        if (ok !== 1'b1) $display("FAIL live_wait: got slot %0d expected 4", cur_slot);
        else passes++;
        lut_conf_sel = 3'd1; lut_conf_slot = 3'd5; lut_conf_data = 3'd4; config_node = 4'd4;
        lut_conf_valid = 1'b1;
        @(negedge clk);
        lut_conf_valid = 1'b0;
        checks++;
        if (cur_slot !== 3'd5) $display("FAIL live_slot: got %0d expected 5", cur_slot);
        else passes++;
        checks++;
        if (out_sel[1] !== 3'd6) $display("FAIL live_old: got %0d expected 6", out_sel[1]);
        else passes++;
        m_tab[1][5] = 3'd4;
        repeat (8) @(negedge clk);
        checks++;
        if (cur_slot !== 3'd5) $display("FAIL live_slot_next: got %0d expected 5", cur_slot);
        else passes++;
        checks++;
        if (out_sel[1] !== 3'd4) $display("FAIL live_new: got %0d expected 4", out_sel[1]);
        else passes++;
    endtask

    task automatic test_sync();
        bit ok;
        wait_slot(5, ok);
        tdm_sync = 1'b1;
        @(negedge clk);
        tdm_sync = 1'b0;
        checks++;
        if (cur_slot !== 3'd0) $display("FAIL sync5_slot: got %0d expected 0", cur_slot);
        else passes++;
        checks++;
        if (out_sel !== exp_vec(0)) $display("FAIL sync5_out: got %h expected %h", out_sel, exp_vec(0));
        else passes++;
        @(negedge clk);
        checks++;
        if (cur_slot !== 3'd1) $display("FAIL sync5_next: got %0d expected 1", cur_slot);
        else passes++;
        checks++;
        if (out_sel !== exp_vec(1)) $display("FAIL sync5_out1: got %h expected %h", out_sel, exp_vec(1));
        else passes++;
        wait_slot(7, ok);
        tdm_sync = 1'b1;
        @(negedge clk);
        tdm_sync = 1'b0;
        checks++;
        if (cur_slot !== 3'd0) $display("FAIL sync7_slot: got %0d expected 0", cur_slot);
        else passes++;
        @(negedge clk);
        checks++;
        if (cur_slot !== 3'd1) $display("FAIL sync7_next: got %0d expected 1", cur_slot);
        else passes++;
    endtask

    task automatic test_reset_mid();
        checks++;
        if (conf_error !== 1'b1) $display("FAIL mid_pre_err: got %0b expected 1", conf_error);
        else passes++;
        #2 rst = 1'b0;
        clear_model();
        #1;
        checks++;
        if (cur_slot !== 3'd0) $display("FAIL mid_cur_slot: got %0d expected 0", cur_slot);
        else passes++;
        checks++;
        if (conf_error !== 1'b0) $display("FAIL mid_conf_error: got %0b expected 0", conf_error);
        else passes++;
        checks++;
        if (out_sel !== exp_vec(0)) $display("FAIL mid_out_sel: got %h expected %h", out_sel, exp_vec(0));
        else passes++;
        lut_conf_sel = 3'd5; lut_conf_slot = 3'd2; lut_conf_data = 3'd0; config_node = 4'd4;
        lut_conf_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lut_conf_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cur_slot !== 3'(i)) $display("FAIL mid_sweep_slot_%0d: got %0d expected %0d", i, cur_slot, i);
            else passes++;
            checks++;
            if (out_sel !== exp_vec(i)) $display("FAIL mid_sweep_out_%0d: got %h expected %h", i, out_sel, exp_vec(i));
            else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_range();
        bit ok;
        reset_dut();
        do_write(0, 0, 7, 4);
        checks++;
        if (conf_error !== 1'b1) $display("FAIL range_data_err: got %0b expected 1", conf_error);
        else passes++;
        wait_slot(0, ok);
        checks++;
        if (out_sel !== exp_vec(0)) $display("FAIL range_data_out: got %h expected %h", out_sel, exp_vec(0));
        else passes++;
        reset_dut();
        do_write(6, 0, 0, 4);
        checks++;
        if (conf_error !== 1'b1) $display("FAIL range_sel_err: got %0b expected 1", conf_error);
        else passes++;
        reset_dut();
        do_write(5, 2, 0, 4);
        checks++;
        if (conf_error !== 1'b0) $display("FAIL range_ok_err: got %0b expected 0", conf_error);
        else passes++;
        m_tab[5][2] = 3'd0;
        wait_slot(2, ok);
        checks++;
        if (out_sel !== exp_vec(2)) $display("FAIL range_ok_out: got %h expected %h", out_sel, exp_vec(2));
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_wrap();
        test_foreign();
        test_basic_write();
        test_conflict();
        test_live_slot();
        test_sync();
        test_reset_mid();
        test_range();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
